// File: rtl/deser8_if.sv
// deser8_if: serial-side inputs and parallel-side outputs of the 1:8 deserializer.
// Ports: CE/D/CALIB flow from the stream source; Q0..Q7/VALID flow back to the consumer.
// master = stream source / word consumer, slave = the deserializer itself.
interface deser8_if;
    logic CE;
    logic D;
    logic CALIB;
    logic Q0;
    logic Q1;
    logic Q2;
    logic Q3;
    logic Q4;
    logic Q5;
    logic Q6;
    logic Q7;
    logic VALID;

    modport master (
        output CE, D, CALIB,
        input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, VALID
    );

    modport slave (
        input  CE, D, CALIB,
        output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, VALID
    );
endinterface

// File: rtl/deser8.sv
// deser8: 1:8 serial-to-parallel deserializer with one-bit-per-request slip alignment.
// Latency: 8th bit of a word sampled at edge N -> Q0..Q7 and VALID registered, seen in cycle N+1.
// Backpressure: none; D is consumed on every CE=1 cycle, words are never stalled or dropped.
// Ports: CLK, RESET (async, active-high), bus (deser8_if.slave: CE, D, CALIB in; Q0..Q7, VALID out).
module deser8 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic    CLK,
    input logic    RESET,
    deser8_if.slave bus
);

    logic [7:0] sr;
    logic [2:0] cnt;
    logic       calib_d;
    logic       slip_pend;
    logic [7:0] q_r;
    logic       valid_r;

    logic       calib_rise;
    logic [7:0] word;
    logic [7:0] word_mapped;

    assign calib_rise = bus.CALIB & ~calib_d;

    // Newest bit enters at the top, so after eight shifts the first bit of
    // the word sits at bit 0.
    assign word = {bus.D, sr[7:1]};

    always_comb begin
        word_mapped = word;
        if (!LSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                word_mapped[i] = word[7-i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sr        <= 8'd0;
            cnt       <= 3'd0;
            calib_d   <= 1'b0;
            slip_pend <= 1'b0;
            q_r       <= 8'd0;
            valid_r   <= 1'b0;
        end else begin
            calib_d <= bus.CALIB;
            valid_r <= 1'b0;
            if (bus.CE) begin
                sr <= word;
                if (slip_pend) begin
                    // Swallow this bit from the count: the word boundary moves
                    // one bit later. An edge seen now is dropped, slips never queue.
                    slip_pend <= 1'b0;
                end else begin
                    cnt <= cnt + 3'd1;
                    if (calib_rise) begin
                        slip_pend <= 1'b1;
                    end
                    if (cnt == 3'd7) begin
                        q_r     <= word_mapped;
                        valid_r <= 1'b1;
                    end
                end
            end else if (calib_rise) begin
                slip_pend <= 1'b1;
            end
        end
    end

    assign bus.Q0    = q_r[0];
    assign bus.Q1    = q_r[1];
    assign bus.Q2    = q_r[2];
    assign bus.Q3    = q_r[3];
    assign bus.Q4    = q_r[4];
    assign bus.Q5    = q_r[5];
    assign bus.Q6    = q_r[6];
    assign bus.Q7    = q_r[7];
    assign bus.VALID = valid_r;

endmodule

// File: tb/tb_deser8.sv
// tb_deser8: drives one stream into LSB-first and MSB-first deser8 instances and
// compares every cycle against a bit-history reference model, plus directed
// checks of word values, VALID spacing and slip behaviour.
module tb_deser8;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic ce    = 1'b0;
    logic d     = 1'b0;
    logic calib = 1'b0;

    always #5 CLK = ~CLK;

    deser8_if ifl ();
    deser8_if ifm ();

    assign ifl.CE    = ce;
    assign ifl.D     = d;
    assign ifl.CALIB = calib;
    assign ifm.CE    = ce;
    assign ifm.D     = d;
    assign ifm.CALIB = calib;

    deser8 #(.LSB_FIRST(1'b1)) u_lsb (.CLK(CLK), .RESET(RESET), .bus(ifl));
    deser8 #(.LSB_FIRST(1'b0)) u_msb (.CLK(CLK), .RESET(RESET), .bus(ifm));

    logic [7:0] q_l;
    logic [7:0] q_m;
    assign q_l = {ifl.Q7, ifl.Q6, ifl.Q5, ifl.Q4, ifl.Q3, ifl.Q2, ifl.Q1, ifl.Q0};
    assign q_m = {ifm.Q7, ifm.Q6, ifm.Q5, ifm.Q4, ifm.Q3, ifm.Q2, ifm.Q1, ifm.Q0};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remembers the last eight sampled bits, counts bits that
    // belong to the current word, and tracks whether a slip is owed.
    bit         hist[$];
    int         m_nbits;
    bit         m_slip;
    bit         m_cprev;
    logic [7:0] m_ql;
    logic [7:0] m_qm;
    bit         m_valid;

    task automatic model_reset();
        hist.delete();
        m_nbits = 0;
        m_slip  = 0;
        m_cprev = 0;
        m_ql    = 8'd0;
        m_qm    = 8'd0;
        m_valid = 0;
    endtask

    task automatic model_edge();
        bit rise;
        rise    = calib && !m_cprev;
        m_cprev = calib;
        m_valid = 0;
        if (ce) begin
            hist.push_back(d);
            if (hist.size() > 8) void'(hist.pop_front());
            if (m_slip) begin
                m_slip = 0;
            end else begin
                m_nbits++;
                if (rise) m_slip = 1;
                if (m_nbits == 8) begin
                    m_nbits = 0;
                    m_valid = 1;
                    for (int i = 0; i < 8; i++) begin
                        m_ql[i]   = hist[i];
                        m_qm[7-i] = hist[i];
                    end
                end
            end
        end else if (rise) begin
            m_slip = 1;
        end
    endtask

    int cyc    = 0;
    int last_v = 0;
    int gap    = 0;
    int gap9   = 0;
    int nv     = 0;

    task automatic step(input bit ce_i, input bit d_i, input bit calib_i);
        ce    = ce_i;
        d     = d_i;
        calib = calib_i;
        @(posedge CLK);
        model_edge();
        cyc++;
        #1;
        check("valid_l", ifl.VALID, m_valid);
        check("valid_m", ifm.VALID, m_valid);
        check("q_l", q_l, m_ql);
        check("q_m", q_m, m_qm);
        if (ifl.VALID === 1'b1) begin
            gap    = cyc - last_v;
            last_v = cyc;
            nv++;
            if (gap == 9) gap9++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int spacing);
        for (int i = 0; i < 8; i++) begin
            for (int k = 1; k < spacing; k++) step(1'b0, 1'b0, 1'b0);
            step(1'b1, b[i], 1'b0);
        end
    endtask

    // Repeating A5 stream; CALIB is high for stream positions [c0, c1).
    logic [7:0] pat = 8'hA5;
    int         sidx = 0;

    task automatic stream(input int n, input int c0, input int c1);
        for (int j = 0; j < n; j++) begin
            step(1'b1, pat[sidx % 8], (j >= c0) && (j < c1));
            sidx++;
        end
    endtask

    // Called at edge+1: asserts RESET mid-cycle, checks outputs clear at once,
    // releases RESET just after the following edge.
    task automatic do_reset();
        #2;
        RESET = 1'b1;
        #1;
        check("rst_valid_l", ifl.VALID, 1'b0);
        check("rst_valid_m", ifm.VALID, 1'b0);
        check("rst_q_l", q_l, 8'd0);
        check("rst_q_m", q_m, 8'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        sidx  = 0;
    endtask

    initial begin
        model_reset();
        #2;
        RESET = 1'b1;
        #1;
        check("init_valid", ifl.VALID, 1'b0);
        check("init_q_l", q_l, 8'd0);
        check("init_q_m", q_m, 8'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Idle with CE low: nothing may change.
        for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom), 1'b0);
        check("idle_nv", nv, 0);

        // Basic words, back to back, both bit orders.
        send_byte(8'hA5, 1);
        check("a5_valid", ifl.VALID, 1'b1);
        check("a5_q_l", q_l, 8'hA5);
        check("a5_q_m", q_m, 8'hA5);
        send_byte(8'h3C, 1);
        check("3c_q_l", q_l, 8'h3C);
        check("3c_period", gap, 8);
        send_byte(8'h01, 1);
        check("01_q_l", q_l, 8'h01);
        check("01_q_m", q_m, 8'h80);

        // Async reset right on a VALID cycle.
        do_reset();

        // Single slip: one 9-cycle gap, words become A5 rotated by one.
        stream(16, 99, 0);
        gap9 = 0;
        stream(24, 3, 4);
        check("slip_gap9", gap9, 1);
        check("slip_q", q_l, 8'hD2);
        for (int p = 0; p < 7; p++) stream(16, 2, 3);
        stream(16, 99, 0);
        check("restore_q", q_l, 8'hA5);

        // CALIB held high for 10 cycles: only one slip.
        gap9 = 0;
        stream(10, 0, 10);
        stream(16, 99, 0);
        check("hold_gap9", gap9, 1);
        check("hold_q", q_l, 8'hD2);

        // Two pulses while CE is low: one slip on the next CE.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        stream(24, 99, 0);
        check("two_pulse_q", q_l, 8'h69);

        // CALIB high through reset release: first CE bit is swallowed.
        calib = 1'b1;
        do_reset();
        nv = 0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        send_byte(8'h5A, 1);
        check("calrst_valid", ifl.VALID, 1'b1);
        check("calrst_q", q_l, 8'h5A);
        check("calrst_nv", nv, 1);

        // Sparse CE, every third cycle.
        do_reset();
        send_byte(8'h5A, 3);
        check("sparse_valid", ifl.VALID, 1'b1);
        check("sparse_q", q_l, 8'h5A);
        step(1'b0, 1'b0, 1'b0);
        check("sparse_pulse", ifl.VALID, 1'b0);

        // Reset after five bits: the partial word is discarded.
        nv = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        do_reset();
        send_byte(8'hFF, 1);
        check("partial_q", q_l, 8'hFF);
        check("partial_nv", nv, 1);

        // Random traffic with occasional slips.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/deser8.md
# deser8

Single-clock 1:8 deserializer with bit-slip alignment, the receive-side counterpart of the team's 8:1 mux/serializer primitives in the Gowin simulation library. It collects a serial bit stream sampled on clock-enable cycles into 8-bit parallel words and flags each completed word. It provides Verilator-compatible behaviour for designs that time-multiplex eight signals onto one wire. The CALIB input shifts word alignment by one bit per request.

## Interface
- LSB_FIRST, default 1: 1 = first received bit of a word appears on Q0; 0 = first received bit appears on Q7.
- CLK  input  1  sole clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- CE  input  1  bit-sample enable; D is consumed only on cycles with CE=1.
- D  input  1  serial data.
- CALIB  input  1  bit-slip request; rising-edge sensitive.
- Q0..Q7  output  1 each  parallel word, registered, held between words.
- VALID  output  1  one-cycle pulse: a new word was loaded onto Q0..Q7.

## Operation
- State: sr[7:0] shift register, cnt[2:0] bit counter, calib_d (CALIB delayed), slip_pend, Q register, VALID register.
- Reset (asynchronous, while RESET=1): sr=0, cnt=0, Q0..Q7=0, VALID=0, calib_d=0, slip_pend=0. Reset mid-word discards the partial word. No VALID is produced for the discarded word.
- Every cycle: calib_d <= CALIB. A rising edge is CALIB=1 with calib_d=0. It sets slip_pend=1. A further edge while slip_pend=1 is ignored; slips do not accumulate.
- CALIB held high at reset release counts as one rising edge on the first clock.
- CE=1 cycle, normal case (slip_pend=0):
  - sr <= {D, sr[7:1]}.
  - cnt <= cnt+1, wrapping 7 -> 0.
  - If cnt==7: load the word {D, sr[7:1]} into Q and set VALID=1 for the next cycle.
- CE=1 cycle with slip_pend=1:
  - sr shifts in D as normal.
  - cnt is held and slip_pend is cleared.
  - No word is emitted, even if cnt==7.
  - Net effect: the word boundary moves one bit later.
- Edge and CE in the same cycle with slip_pend=0: the edge sets slip_pend. The slip applies on the next CE=1 cycle; the current cycle advances normally.
- CE=0 cycle: sr, cnt and Q hold, VALID=0. Only calib_d and slip_pend update.
- Bit mapping:
  - LSB_FIRST=1: Q[i] = bit received i-th within the word, with i=0 the first bit.
  - LSB_FIRST=0: Q[7-i] = i-th bit.
- Q changes only when VALID is asserted.

## Timing
- Latency: the 8th bit of a word is sampled at edge N. Q0..Q7 and VALID are both valid after edge N, i.e. during cycle N+1. VALID drops after edge N+1 unless another word completes.
- With CE=1 continuously: VALID rate is 1 in 8 cycles. A slip gives exactly one 9-cycle gap.
- With sparse CE: a word completes on the 8th non-slipped CE cycle. VALID remains a one-cycle pulse regardless of the CE duty cycle.
- CALIB edge detection latency: an edge sampled at edge M affects the first CE=1 edge strictly after M.
- No combinational path from any input to any output.

## Test plan
- Reset/idle: assert RESET asynchronously mid-cycle -> Q0..Q7=0 and VALID=0 immediately. After release with CE=0 for 20 cycles, outputs stay 0.
- Basic word: LSB_FIRST=1, CE=1. Send bits 1,0,1,0,0,1,0,1, i.e. 8'hA5 LSB first -> VALID high exactly one cycle after the 8th bit, Q7..Q0 = 8'hA5.
  - Repeat with 8'h3C back-to-back -> VALID period of 8 cycles.
- Bit order: LSB_FIRST=0, same stream -> Q7..Q0 = 8'hA5 bit-reversed = 8'hA5 (palindrome), so also send 8'h01 -> Q7..Q0 = 8'h80.
- Bit slip: stream of repeating 8'hA5 with a single CALIB pulse -> one 9-cycle VALID gap. Subsequent words equal 8'hA5 rotated by one bit, i.e. 8'hD2. Eight pulses restore 8'hA5.
- CALIB edge cases:
  - CALIB held high for 10 cycles -> exactly one slip.
  - Two pulses before any CE=1 cycle -> one slip.
  - CALIB high through reset release -> one slip after reset.
- Sparse CE and reset mid-word: CE=1 every 3rd cycle, 8'h5A -> VALID one cycle after the 8th CE edge with Q = 8'h5A.
  - RESET after 5 bits, then 8 new bits of 8'hFF -> Q = 8'hFF, with no VALID for the partial word.
